pipe_skid_stage: RTL and testbench

// - Parametrised successor to the fixed decode->execute pipeline register.
// - Moves a control word plus NCH operand channels across one pipeline boundary.
// - Two-entry skid buffer with valid/ready handshake; full throughput when out_ready is held high.
// - Adds synchronous flush (bubble insertion), back-pressure and a saturating stall counter.
// - Instantiated between the decode and execute stages; generic enough for later boundaries.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/sat_counter.sv | 16 +
 rtl/pipe_skid_stage.sv | 111 +++++++++++
 tb/tb_pipe_skid_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and control-word field positions for the pipeline boundary stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int CTRL_W_DEF = 14;

  // {regw,memw,regmem,branch,ALUope,flag,ALUctrl[3:0],regScr[3:0]}
  localparam int CTRL_REGW        = 13;
  localparam int CTRL_MEMW        = 12;
  localparam int CTRL_REGMEM      = 11;
  localparam int CTRL_BRANCH      = 10;
  localparam int CTRL_ALUOPE      = 9;
  localparam int CTRL_FLAG        = 8;
  localparam int CTRL_ALUCTRL_MSB = 7;
  localparam int CTRL_ALUCTRL_LSB = 4;
  localparam int CTRL_REGSCR_MSB  = 3;
  localparam int CTRL_REGSCR_LSB  = 0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; only reset clears it.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           value <= '0;
    else if (inc && (value != {W{1'b1}})) value <= value + 1'b1;
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer carrying a control word plus NCH operand channels across
// one pipeline boundary, with synchronous flush and a saturating stall counter.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = 32,
  parameter int NCH    = 3,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [NCH*DATA_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]      stall_cnt
);

  state_t                     state_q, state_d;
  logic [CTRL_W-1:0]          head_ctrl, skid_ctrl;
  logic [NCH-1:0][DATA_W-1:0] head_data, skid_data;
  logic                       in_ready_q;
  logic                       accept, drain;
  logic                       ld_head_in, ld_head_skid, ld_skid;

  assign accept    = in_valid && in_ready_q;
  assign drain     = out_valid && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);

  // Bubbles are forced to zero so regw/memw can never fire downstream.
  assign out_ctrl  = out_valid ? head_ctrl : '0;
  assign out_data  = out_valid ? head_data : '0;

  always_comb begin
    state_d      = state_q;
    ld_head_in   = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          ld_head_in = 1'b1;
          state_d    = ONE;
        end
        ONE: begin
          if (accept && drain) begin
            ld_head_in = 1'b1;
          end else if (accept) begin
            ld_skid = 1'b1;
            state_d = TWO;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: if (drain) begin
          ld_head_skid = 1'b1;
          state_d      = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ctrl <= '0;
      head_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (ld_head_in) begin
        head_ctrl <= in_ctrl;
        head_data <= in_data;
      end else if (ld_head_skid) begin
        head_ctrl <= skid_ctrl;
        head_data <= skid_data;
      end
      if (ld_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid && !out_ready),
    .value (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench: the driver queues every accepted entry, the monitor pops on each drain.
module tb_pipe_skid_stage;

  localparam int EW = 110;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [13:0] in_ctrl, out_ctrl;
  logic [95:0] in_data, out_data;
  logic [15:0] stall_cnt;
  logic        in_ready_s, out_valid_s;
  logic [13:0] out_ctrl_s;
  logic [95:0] out_data_s;
  logic [3:0]  stall_s;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  int checks = 0;
  int errors = 0;
  int waited;

  pipe_skid_stage u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt)
  );

  pipe_skid_stage #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_ctrl(out_ctrl_s), .out_data(out_data_s), .stall_cnt(stall_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, exp);
    end
  endtask

  // Holds the entry on the inputs until the stage takes it; queues the expected output.
  task automatic send(input logic [13:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] m, output int w);
    bit done;
    done     = 1'b0;
    w        = 0;
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = {m, b, a};
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({c, m, b, a});
        done = 1'b1;
      end else begin
        w++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout ctrl %0h not accepted, required acceptance", c);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out got %0h required no entry", {out_ctrl, out_data});
        end else begin
          exp_e = exp_q.pop_front();
          check("fifo_order", EW'({out_ctrl, out_data}), exp_e);
        end
      end
      if (!out_valid) check("bubble_zero", EW'({out_ctrl, out_data}), EW'(0));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_ctrl = '0; in_data = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", EW'(out_valid), EW'(0));
    check("rst_in_ready",  EW'(in_ready),  EW'(1));
    check("rst_out_ctrl",  EW'(out_ctrl),  EW'(0));
    check("rst_stall_cnt", EW'(stall_cnt), EW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1);

    // Streaming: exact first entry, then back-to-back with no wait
    send(14'h2D53, 32'h0000FFFF, 32'h00000801, 32'h0, waited);
    check("stream_valid", EW'(out_valid), EW'(1));
    check("stream_ctrl",  EW'(out_ctrl),  EW'(14'h2D53));
    check("stream_data",  EW'(out_data),  EW'({32'h0, 32'h00000801, 32'h0000FFFF}));
    for (int i = 1; i <= 5; i++) begin
      send(14'(14'h0100 + i), 32'hA0000000 + i, 32'hB0000000 + i, 32'h0 + i, waited);
      check("stream_no_wait", EW'(waited), EW'(0));
    end
    step(1);
    check("stream_stall0", EW'(stall_cnt), EW'(0));

    // Back-pressure: A, B fill both entries, C held off until release
    out_ready = 1'b0;
    send(14'h0AAA, 32'h1, 32'h2, 32'h3, waited);
    send(14'h0BBB, 32'h4, 32'h5, 32'h6, waited);
    check("bp_in_ready0", EW'(in_ready),  EW'(0));
    check("bp_stall1",    EW'(stall_cnt), EW'(1));
    fork
      send(14'h0CCC, 32'h7, 32'h8, 32'h9, waited);
      begin
        step(1);
        check("bp_stall2", EW'(stall_cnt), EW'(2));
        step(1);
        check("bp_stall3", EW'(stall_cnt), EW'(3));
        check("bp_hold",   EW'(in_ready),  EW'(0));
        out_ready = 1'b1;
      end
    join
    step(1);
    check("bp_stall_final", EW'(stall_cnt), EW'(3));

    // Flush with a same-cycle input that must be dropped
    out_ready = 1'b0;
    send(14'h0A0A, 32'h11, 32'h12, 32'h13, waited);
    send(14'h0B0B, 32'h14, 32'h15, 32'h16, waited);
    check("fl_two", EW'(in_ready), EW'(0));
    flush = 1'b1; in_valid = 1'b1; in_ctrl = 14'h1111; in_data = {3{32'h1111}};
    step(1);
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("fl_out_valid", EW'(out_valid), EW'(0));
    check("fl_out_ctrl",  EW'(out_ctrl),  EW'(0));
    check("fl_out_data",  EW'(out_data),  EW'(0));
    check("fl_in_ready",  EW'(in_ready),  EW'(1));
    check("fl_stall",     EW'(stall_cnt), EW'(5));
    out_ready = 1'b1;
    step(3);

    // Random gaps, consumer always ready: accept and drain coincide in ONE
    for (int i = 0; i < 10; i++) begin
      send(14'(14'h0200 + i), 32'hC0000000 + i, 32'hD0000000 + i, 32'h00000100 + i, waited);
      check("rnd_no_wait", EW'(waited), EW'(0));
      step($urandom_range(0, 2));
    end
    step(1);
    check("rnd_stall", EW'(stall_cnt), EW'(5));

    // Saturation of the 4-bit counter while the main counter keeps going
    out_ready = 1'b0;
    send(14'h3FFF, 32'hDEADBEEF, 32'h0, 32'h5, waited);
    step(10);
    check("sat_main15", EW'(stall_cnt), EW'(15));
    check("sat_cnt_f",  EW'(stall_s),   EW'(4'hF));
    step(10);
    check("sat_main25", EW'(stall_cnt), EW'(25));
    check("sat_hold",   EW'(stall_s),   EW'(4'hF));
    check("sat_head", EW'({out_valid_s, in_ready_s, out_ctrl_s, out_data_s}),
          EW'({1'b1, 1'b1, 14'h3FFF, 32'h5, 32'h0, 32'hDEADBEEF}));
    out_ready = 1'b1;
    step(1);
    check("all_drained", EW'(exp_q.size()), EW'(0));

    // Asynchronous reset mid-cycle while holding two entries
    out_ready = 1'b0;
    send(14'h0123, 32'h21, 32'h22, 32'h23, waited);
    send(14'h0456, 32'h24, 32'h25, 32'h26, waited);
    check("ar_two", EW'(in_ready), EW'(0));
    #3 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("ar_out_valid", EW'(out_valid), EW'(0));
    check("ar_in_ready",  EW'(in_ready),  EW'(1));
    check("ar_out_ctrl",  EW'(out_ctrl),  EW'(0));
    check("ar_stall",     EW'(stall_cnt), EW'(0));
    check("ar_stall_sat", EW'(stall_s),   EW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
